servo_scan_ctrl: RTL

SERVO_SCAN_CTRL -- requirements
Module: servo_scan_ctrl

---
 rtl/servo_scan_ctrl.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/servo_scan_ctrl.sv
// rtl/servo_scan_ctrl.sv - three-position ultrasonic scan sequencer for a PWM servo
//
// Sweeps the servo right, centre, left, measuring a range sample at each
// position after a settle time, then returns to centre and pulses done.
//
// Parameters:
//   FRAME_CYCLES   clkpwm cycles per 20 ms servo frame
//   SETTLE_FRAMES  frames held at a position before measuring
//   TIMEOUT_FRAMES frames allowed for meas_ack (timeout build only)
//
// Ports:
//   clkpwm        clock, rising edge
//   reset         synchronous, active-high
//   start         one-cycle scan request (ignored while busy)
//   abort         level; ends the scan and recentres the servo
//   meas_ack      one-cycle sensor completion, qualifies meas_data
//   meas_data     8-bit distance sample
//   grados        position code: 10 right, 00 centre, 01 left
//   pwm_en        PWM generator enable
//   meas_req      measurement request level
//   busy          high outside IDLE
//   done          one-cycle pulse at end of scan
//   dist_r/c/l    last captured samples per position
//   timeout_flag  sticky measurement timeout
//
// Build option: define SERVO_SCAN_TIMEOUT_EN to abandon a measurement after
// TIMEOUT_FRAMES frames, storing 8'hFF; otherwise MEASURE waits forever.

module servo_scan_ctrl #(
  parameter int FRAME_CYCLES   = 400,
  parameter int SETTLE_FRAMES  = 25,
  parameter int TIMEOUT_FRAMES = 10
) (
  input  logic       clkpwm,
  input  logic       reset,
  input  logic       start,
  input  logic       abort,
  input  logic       meas_ack,
  input  logic [7:0] meas_data,
  output logic [1:0] grados,
  output logic       pwm_en,
  output logic       meas_req,
  output logic       busy,
  output logic       done,
  output logic [7:0] dist_r,
  output logic [7:0] dist_c,
  output logic [7:0] dist_l,
  output logic       timeout_flag
);

  localparam int FW      = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
  // One frame-tick counter serves both the settle and timeout intervals.
  localparam int CNT_MAX = (SETTLE_FRAMES > TIMEOUT_FRAMES) ? SETTLE_FRAMES : TIMEOUT_FRAMES;
  localparam int TW      = $clog2(CNT_MAX + 1);

  localparam logic [1:0] POS_R = 2'b10;
  localparam logic [1:0] POS_C = 2'b00;
  localparam logic [1:0] POS_L = 2'b01;

  typedef enum logic [2:0] {IDLE, MOVE, MEASURE, RETURN, FINISH} state_t;

  state_t          state, state_n;
  logic [1:0]      pos, pos_n;
  logic [FW-1:0]   frame_cnt, frame_n;
  logic [TW-1:0]   tick_cnt, tick_n;
  logic [7:0]      dr_n, dc_n, dl_n;
  logic            tflag, tflag_n;
  logic            frame_tick;
  logic            capture;
  logic [7:0]      cap_data;

  assign frame_tick = (frame_cnt == FW'(FRAME_CYCLES - 1));

  always_ff @(posedge clkpwm) begin
    if (reset) begin
      state     <= IDLE;
      pos       <= POS_C;
      frame_cnt <= '0;
      tick_cnt  <= '0;
      dist_r    <= '0;
      dist_c    <= '0;
      dist_l    <= '0;
      tflag     <= 1'b0;
    end else begin
      state     <= state_n;
      pos       <= pos_n;
      frame_cnt <= frame_n;
      tick_cnt  <= tick_n;
      dist_r    <= dr_n;
      dist_c    <= dc_n;
      dist_l    <= dl_n;
      tflag     <= tflag_n;
    end
  end

  always_comb begin
    state_n  = state;
    pos_n    = pos;
    frame_n  = frame_tick ? '0 : frame_cnt + 1'b1;
    tick_n   = tick_cnt + {{(TW-1){1'b0}}, frame_tick};
    dr_n     = dist_r;
    dc_n     = dist_c;
    dl_n     = dist_l;
    tflag_n  = tflag;
    capture  = 1'b0;
    cap_data = meas_data;

    case (state)
      IDLE: begin
        if (start) begin
          state_n = MOVE;
          pos_n   = POS_R;
          frame_n = '0;
          tick_n  = '0;
          tflag_n = 1'b0;
        end
      end
      MOVE: begin
        if (abort) begin
          state_n = RETURN;
          frame_n = '0;
          tick_n  = '0;
        end else if (frame_tick && tick_cnt == TW'(SETTLE_FRAMES - 1)) begin
          // frame_n wraps to 0 here, so MEASURE starts on a frame boundary.
          state_n = MEASURE;
          tick_n  = '0;
        end
      end
      MEASURE: begin
        if (abort) begin
          state_n = RETURN;
          frame_n = '0;
          tick_n  = '0;
        end else if (meas_ack) begin
          capture = 1'b1;
        end
`ifdef SERVO_SCAN_TIMEOUT_EN
        else if (frame_tick && tick_cnt == TW'(TIMEOUT_FRAMES - 1)) begin
          capture  = 1'b1;
          cap_data = 8'hFF;
          tflag_n  = 1'b1;
        end
`endif
      end
      RETURN: begin
        if (frame_tick && tick_cnt == TW'(SETTLE_FRAMES - 1))
          state_n = FINISH;
      end
      FINISH: state_n = IDLE;
      default: state_n = IDLE;
    endcase

    // Store the sample for the current position and advance the sweep.
    if (capture) begin
      frame_n = '0;
      tick_n  = '0;
      case (pos)
        POS_R: begin
          dr_n    = cap_data;
          pos_n   = POS_C;
          state_n = MOVE;
        end
        POS_C: begin
          dc_n    = cap_data;
          pos_n   = POS_L;
          state_n = MOVE;
        end
        default: begin
          dl_n    = cap_data;
          pos_n   = POS_C;
          state_n = RETURN;
        end
      endcase
    end
  end

  // Position is only driven off-centre while sweeping; RETURN and IDLE hold centre.
  assign grados       = (state == MOVE || state == MEASURE) ? pos : POS_C;
  assign pwm_en       = 1'b1;
  assign meas_req     = (state == MEASURE);
  assign busy         = (state != IDLE);
  assign done         = (state == FINISH);
  assign timeout_flag = tflag;

endmodule
